// File: rtl/sram_arbiter.sv
// Shares one asynchronous 16-bit SRAM between a real-time video reader and a host
// read/write port. Video has fixed priority; a wait counter keeps the host from starving.
module sram_arbiter #(
    parameter int READ_CYCLES   = 2,
    parameter int WRITE_CYCLES  = 2,
    parameter int HOST_MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        vidReq,
    input  logic [17:0] vidAddr,
    output logic        vidAck,
    output logic [15:0] vidData,
    output logic        vidValid,
    input  logic        hostReq,
    input  logic        hostWe,
    input  logic [17:0] hostAddr,
    input  logic [15:0] hostWData,
    input  logic [1:0]  hostByteEn,
    output logic        hostAck,
    output logic [15:0] hostRData,
    output logic        hostRValid,
    output logic [17:0] ram_addr,
    input  logic [15:0] ram_din,
    output logic [15:0] ram_dout,
    output logic        ram_ce,
    output logic        ram_oe,
    output logic        ram_we,
    output logic        ram_lb,
    output logic        ram_hb
);

    localparam int CNT_MAX = (READ_CYCLES > WRITE_CYCLES) ? READ_CYCLES : WRITE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int WAIT_W  = $clog2(HOST_MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]  RD_LAST  = CNT_W'(READ_CYCLES - 1);
    localparam logic [CNT_W-1:0]  WR_LAST  = CNT_W'(WRITE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(HOST_MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

    typedef enum logic [2:0] {IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
    logic [17:0]       addr_q, addr_d;
    logic [15:0]       dout_q, dout_d;
    logic [1:0]        be_q, be_d;
    logic              rdHost_q, rdHost_d;
    logic              vidAck_q, vidAck_d, hostAck_q, hostAck_d;
    logic              vidValid_q, vidValid_d, hostValid_q, hostValid_d;
    logic [15:0]       vidData_q, vidData_d, hostRData_q, hostRData_d;
    logic              ce_q, ce_d, oe_q, oe_d, we_q, we_d, lb_q, lb_d, hb_q, hb_d;

    logic vidReqEff, hostReqEff, arbPoint, hostWin, vidWin;
    logic readGrant, writeGrant, wrState;

    // A requester whose ack is showing has already been served; it must not win again.
    assign vidReqEff  = vidReq && !vidAck_q;
    assign hostReqEff = hostReq && !hostAck_q;
    assign arbPoint   = (state_q == IDLE) || ((state_q == READ) && (cnt_q == RD_LAST));
    assign hostWin    = hostReqEff && (!vidReqEff || (waitCnt_q == WAIT_MAX));
    assign vidWin     = !hostWin && vidReqEff;
    assign readGrant  = arbPoint && (vidWin || (hostWin && !hostWe));
    assign writeGrant = (state_q == IDLE) && hostWin && hostWe;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        waitCnt_d   = waitCnt_q;
        addr_d      = addr_q;
        dout_d      = dout_q;
        be_d        = be_q;
        rdHost_d    = rdHost_q;
        vidAck_d    = 1'b0;
        hostAck_d   = 1'b0;
        vidValid_d  = 1'b0;
        hostValid_d = 1'b0;
        vidData_d   = vidData_q;
        hostRData_d = hostRData_q;

        case (state_q)
            IDLE: begin
                if (readGrant) begin
                    state_d = READ;
                    cnt_d   = '0;
                end else if (writeGrant) begin
                    state_d = WR_SETUP;
                end
            end
            READ: begin
                if (cnt_q == RD_LAST) begin
                    if (rdHost_q) begin
                        hostRData_d = ram_din;
                        hostValid_d = 1'b1;
                    end else begin
                        vidData_d  = ram_din;
                        vidValid_d = 1'b1;
                    end
                    // Pending write or nothing to do: one turnaround cycle with oe low.
                    state_d = readGrant ? READ : IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            WR_SETUP: begin
                state_d = WR_PULSE;
                cnt_d   = '0;
            end
            WR_PULSE: begin
                if (cnt_q == WR_LAST) begin
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            WR_HOLD:  state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        if (readGrant) begin
            addr_d    = hostWin ? hostAddr : vidAddr;
            rdHost_d  = hostWin;
            hostAck_d = hostWin;
            vidAck_d  = !hostWin;
        end else if (writeGrant) begin
            addr_d    = hostAddr;
            dout_d    = hostWData;
            be_d      = hostByteEn;
            hostAck_d = 1'b1;
        end

        if (!hostReq || hostAck_q || hostAck_d) begin
            waitCnt_d = '0;
        end else if (waitCnt_q != WAIT_MAX) begin
            waitCnt_d = waitCnt_q + WAIT_ONE;
        end

        wrState = (state_d == WR_SETUP) || (state_d == WR_PULSE) || (state_d == WR_HOLD);
        ce_d    = (state_d != IDLE);
        oe_d    = (state_d == READ);
        we_d    = (state_d == WR_PULSE);
        lb_d    = (state_d == READ) || (wrState && be_d[0]);
        hb_d    = (state_d == READ) || (wrState && be_d[1]);
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            waitCnt_q   <= '0;
            addr_q      <= '0;
            dout_q      <= '0;
            be_q        <= '0;
            rdHost_q    <= 1'b0;
            vidAck_q    <= 1'b0;
            hostAck_q   <= 1'b0;
            vidValid_q  <= 1'b0;
            hostValid_q <= 1'b0;
            vidData_q   <= '0;
            hostRData_q <= '0;
            ce_q        <= 1'b0;
            oe_q        <= 1'b0;
            we_q        <= 1'b0;
            lb_q        <= 1'b0;
            hb_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            waitCnt_q   <= waitCnt_d;
            addr_q      <= addr_d;
            dout_q      <= dout_d;
            be_q        <= be_d;
            rdHost_q    <= rdHost_d;
            vidAck_q    <= vidAck_d;
            hostAck_q   <= hostAck_d;
            vidValid_q  <= vidValid_d;
            hostValid_q <= hostValid_d;
            vidData_q   <= vidData_d;
            hostRData_q <= hostRData_d;
            ce_q        <= ce_d;
            oe_q        <= oe_d;
            we_q        <= we_d;
            lb_q        <= lb_d;
            hb_q        <= hb_d;
        end
    end

    assign vidAck     = vidAck_q;
    assign vidData    = vidData_q;
    assign vidValid   = vidValid_q;
    assign hostAck    = hostAck_q;
    assign hostRData  = hostRData_q;
    assign hostRValid = hostValid_q;
    assign ram_addr   = addr_q;
    assign ram_dout   = dout_q;
    assign ram_ce     = ce_q;
    assign ram_oe     = oe_q;
    assign ram_we     = we_q;
    assign ram_lb     = lb_q;
    assign ram_hb     = hb_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural asynchronous SRAM model.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        resetN;
    logic        vidReq;
    logic [17:0] vidAddr;
    logic        vidAck;
    logic [15:0] vidData;
    logic        vidValid;
    logic        hostReq;
    logic        hostWe;
    logic [17:0] hostAddr;
    logic [15:0] hostWData;
    logic [1:0]  hostByteEn;
    logic        hostAck;
    logic [15:0] hostRData;
    logic        hostRValid;
    logic [17:0] ram_addr;
    logic [15:0] ram_din;
    logic [15:0] ram_dout;
    logic        ram_ce;
    logic        ram_oe;
    logic        ram_we;
    logic        ram_lb;
    logic        ram_hb;

    logic [15:0] mem [0:262143];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_arbiter #(
        .READ_CYCLES(2),
        .WRITE_CYCLES(2),
        .HOST_MAX_WAIT(16)
    ) dut (
        .clk(clk), .resetN(resetN),
        .vidReq(vidReq), .vidAddr(vidAddr), .vidAck(vidAck), .vidData(vidData), .vidValid(vidValid),
        .hostReq(hostReq), .hostWe(hostWe), .hostAddr(hostAddr), .hostWData(hostWData),
        .hostByteEn(hostByteEn), .hostAck(hostAck), .hostRData(hostRData), .hostRValid(hostRValid),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .ram_ce(ram_ce), .ram_oe(ram_oe), .ram_we(ram_we), .ram_lb(ram_lb), .ram_hb(ram_hb)
    );

    assign ram_din = (ram_ce && ram_oe) ? mem[ram_addr] : 16'h0000;

    always @(posedge clk) begin
        if (ram_ce && ram_we) begin
            if (ram_lb) mem[ram_addr][7:0]  <= ram_dout[7:0];
            if (ram_hb) mem[ram_addr][15:8] <= ram_dout[15:8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [17:0] vaddr [3];
        int idx, nv, busy, oeMask, ceMask, weMask, vldMask, ackMask;
        int hostAckCyc, vidBefore, vidAfterCyc, rvCyc, both, vldCyc;

        resetN = 1'b0; vidReq = 1'b0; vidAddr = '0; hostReq = 1'b0; hostWe = 1'b0;
        hostAddr = '0; hostWData = '0; hostByteEn = '0;
        mem[18'h00040] <= 16'hBEEF;
        mem[18'h00010] <= 16'h1110;
        mem[18'h00011] <= 16'h1111;
        mem[18'h00012] <= 16'h1112;
        mem[18'h20000] <= 16'hAB00;
        mem[18'h00100] <= 16'h5A5A;
        mem[18'h00200] <= 16'h0000;

        // Reset state
        repeat (3) tick();
        chk("reset_strobes", {27'd0, ram_ce, ram_oe, ram_we, ram_lb, ram_hb}, 32'd0);
        chk("reset_handshake", {28'd0, vidAck, hostAck, vidValid, hostRValid}, 32'd0);
        chk("reset_addr", 32'(ram_addr), 32'd0);
        chk("reset_data", {vidData, hostRData}, 32'd0);
        chk("reset_dout", 32'(ram_dout), 32'd0);

        // Idle with no requests
        resetN = 1'b1;
        busy = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (ram_ce || ram_oe || ram_we || ram_lb || ram_hb ||
                vidAck || hostAck || vidValid || hostRValid) busy++;
        end
        chk("idle_quiet", busy, 32'd0);

        // Single video read
        vidAddr = 18'h00040; vidReq = 1'b1;
        tick();
        chk("rd_ack", 32'(vidAck), 32'd1);
        chk("rd_strobe1", {28'd0, ram_ce, ram_oe, ram_lb, ram_hb}, 32'hF);
        chk("rd_addr", 32'(ram_addr), 32'h40);
        vidReq = 1'b0;
        tick();
        chk("rd_ack_pulse", 32'(vidAck), 32'd0);
        chk("rd_strobe2", {29'd0, ram_ce, ram_oe, ram_we}, 32'h6);
        tick();
        chk("rd_oe_drop", {30'd0, ram_ce, ram_oe}, 32'd0);
        chk("rd_valid", 32'(vidValid), 32'd1);
        chk("rd_data", 32'(vidData), 32'hBEEF);
        tick();
        chk("rd_valid_pulse", 32'(vidValid), 32'd0);

        // Back-to-back video reads
        vaddr[0] = 18'h10; vaddr[1] = 18'h11; vaddr[2] = 18'h12;
        idx = 0; nv = 0; oeMask = 0; vldMask = 0; ackMask = 0;
        vidAddr = vaddr[0]; vidReq = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (ram_oe) oeMask |= (1 << c);
            if (vidValid) begin
                vldMask |= (1 << c);
                chk("b2b_data", 32'(vidData), 32'h1110 + nv);
                nv++;
            end
            if (vidAck) begin
                ackMask |= (1 << c);
                if (idx < 3) chk("b2b_addr", 32'(ram_addr), 32'(vaddr[idx]));
                idx++;
                if (idx < 3) vidAddr = vaddr[idx];
                else vidReq = 1'b0;
            end
        end
        chk("b2b_oe_mask", oeMask, 32'h7E);
        chk("b2b_valid_mask", vldMask, 32'hA8);
        chk("b2b_ack_mask", ackMask, 32'h2A);

        // Host byte-masked write, then readback
        tick();
        hostAddr = 18'h20000; hostWData = 16'h1234; hostByteEn = 2'b01; hostWe = 1'b1; hostReq = 1'b1;
        ceMask = 0; weMask = 0; ackMask = 0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (ram_ce) ceMask |= (1 << c);
            if (ram_we) weMask |= (1 << c);
            if (hostAck) begin
                ackMask |= (1 << c);
                chk("wr_setup_bytes", {30'd0, ram_lb, ram_hb}, 32'h2);
                chk("wr_setup_dout", 32'(ram_dout), 32'h1234);
                chk("wr_addr", 32'(ram_addr), 32'h20000);
                hostReq = 1'b0;
            end
            if (c >= 2 && c <= 4) chk("wr_bytes_held", {30'd0, ram_lb, ram_hb}, 32'h2);
        end
        chk("wr_ce_mask", ceMask, 32'h1E);
        chk("wr_we_mask", weMask, 32'hC);
        chk("wr_ack_mask", ackMask, 32'h2);
        chk("wr_mem", 32'(mem[18'h20000]), 32'hAB34);

        hostWe = 1'b0; hostReq = 1'b1;
        ackMask = 0; vldMask = 0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (hostAck) begin ackMask |= (1 << c); hostReq = 1'b0; end
            if (hostRValid) begin
                vldMask |= (1 << c);
                chk("rb_data", 32'(hostRData), 32'hAB34);
            end
        end
        chk("rb_ack_mask", ackMask, 32'h2);
        chk("rb_valid_mask", vldMask, 32'h8);

        // Host starvation guard against continuous video
        tick();
        vidAddr = 18'h01000; vidReq = 1'b1;
        hostAddr = 18'h00100; hostWe = 1'b0; hostReq = 1'b1;
        hostAckCyc = 0; vidBefore = 0; vidAfterCyc = 0; rvCyc = 0; both = 0;
        for (int c = 1; c <= 24; c++) begin
            tick();
            if (vidAck && hostAck) both++;
            if (hostAck) begin
                if (hostAckCyc == 0) hostAckCyc = c;
                hostReq = 1'b0;
            end
            if (vidAck) begin
                if (hostAckCyc == 0) vidBefore++;
                else if (vidAfterCyc == 0) vidAfterCyc = c;
                vidAddr = vidAddr + 18'd1;
            end
            if (hostRValid) begin
                rvCyc = c;
                chk("starve_data", 32'(hostRData), 32'h5A5A);
            end
        end
        vidReq = 1'b0;
        chk("starve_host_ack_cycle", hostAckCyc, 32'd17);
        chk("starve_vid_before", vidBefore, 32'd8);
        chk("starve_vid_resume", vidAfterCyc, 32'd19);
        chk("starve_rvalid_cycle", rvCyc, 32'd19);
        chk("starve_single_ack", both, 32'd0);
        repeat (6) tick();

        // Host write pending behind an in-flight video read
        vidAddr = 18'h00040; vidReq = 1'b1;
        oeMask = 0; ceMask = 0; weMask = 0; hostAckCyc = 0; vldCyc = 0;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (ram_oe) oeMask |= (1 << c);
            if (ram_ce) ceMask |= (1 << c);
            if (ram_we) weMask |= (1 << c);
            if (vidValid) vldCyc = c;
            if (hostAck) begin hostAckCyc = c; hostReq = 1'b0; end
            if (vidAck) begin
                vidReq = 1'b0;
                hostAddr = 18'h00200; hostWData = 16'hCAFE; hostByteEn = 2'b11;
                hostWe = 1'b1; hostReq = 1'b1;
            end
        end
        tick();
        chk("turn_oe_mask", oeMask, 32'h6);
        chk("turn_ce_mask", ceMask, 32'hF6);
        chk("turn_we_mask", weMask, 32'h60);
        chk("turn_host_ack", hostAckCyc, 32'd4);
        chk("turn_vid_valid", vldCyc, 32'd3);
        chk("turn_mem", 32'(mem[18'h00200]), 32'hCAFE);

        // Reset during the write pulse
        tick();
        hostAddr = 18'h00300; hostWData = 16'h7777; hostByteEn = 2'b11; hostWe = 1'b1; hostReq = 1'b1;
        tick();
        chk("rst_wr_ack", 32'(hostAck), 32'd1);
        hostReq = 1'b0;
        tick();
        chk("rst_pre_we", 32'(ram_we), 32'd1);
        resetN = 1'b0;
        tick();
        chk("rst_strobes", {26'd0, ram_ce, ram_oe, ram_we, ram_lb, ram_hb, hostAck}, 32'd0);
        chk("rst_addr", 32'(ram_addr), 32'd0);
        resetN = 1'b1;
        tick();
        chk("rst_no_retry", {27'd0, ram_ce, ram_we, hostAck, vidAck, hostRValid}, 32'd0);
        vidAddr = 18'h00040; vidReq = 1'b1;
        tick();
        chk("rst_idle_grant", {14'd0, vidAck, ram_oe, ram_addr}, {14'd0, 1'b1, 1'b1, 18'h00040});
        vidReq = 1'b0;
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
